sign_extend_unit: RTL and testbench



---
 rtl/seu_pkg.sv | 11 +
 rtl/seu_ext_comb.sv | 26 ++
 rtl/sign_extend_unit.sv | 64 ++++++
 tb/tb_sign_extend_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/seu_pkg.sv
// Shared constants and word types for the pocket-calculator sign extension unit.
// Optional build macro used by this unit: SEU_ZEXT_EN (adds zero-extension select).
package seu_pkg;

    localparam int SEU_IN_W  = 9;
    localparam int SEU_OUT_W = 16;

    typedef logic [SEU_IN_W-1:0]  imm9_t;
    typedef logic [SEU_OUT_W-1:0] word16_t;

endpackage

// File: rtl/seu_ext_comb.sv
// Combinational widening of an immediate field to a datapath word.
// zext selects zero-fill; otherwise the top bit is replicated.
module seu_ext_comb
    import seu_pkg::*;
#(
    parameter int IN_W  = SEU_IN_W,
    parameter int OUT_W = SEU_OUT_W
) (
    input  logic [IN_W-1:0]  NR,
    input  logic             zext,
    output logic [OUT_W-1:0] ext
);

    generate
        if (OUT_W > IN_W) begin : g_ext
            logic w_fill;

            assign w_fill = zext ? 1'b0 : NR[IN_W-1];
            assign ext    = {{(OUT_W-IN_W){w_fill}}, NR};
        end else begin : g_pass
            // Equal widths: nothing to fill, so zext has no effect.
            assign ext = NR[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/sign_extend_unit.sv
// Registered sign extension of the 9-bit instruction immediate to 16 bits.
// Build macro SEU_ZEXT_EN adds the zext input for zero-extension.
module sign_extend_unit
    import seu_pkg::*;
#(
    parameter int IN_W  = SEU_IN_W,
    parameter int OUT_W = SEU_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  NR,
    input  logic             enable,
`ifdef SEU_ZEXT_EN
    input  logic             zext,
`endif
    output logic [OUT_W-1:0] result,
    output logic             valid
);

    generate
        if (OUT_W < IN_W) begin : g_bad_w
            $error("sign_extend_unit: OUT_W (%0d) must be >= IN_W (%0d)",
                   OUT_W, IN_W);
        end
    endgenerate

    logic             w_zext;
    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] r_result;
    logic             r_valid;

`ifdef SEU_ZEXT_EN
    assign w_zext = zext;
`else
    assign w_zext = 1'b0;
`endif

    seu_ext_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext (
        .NR   (NR),
        .zext (w_zext),
        .ext  (w_ext)
    );

    // Idle cycles load a constant zero, so an undriven NR never reaches result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end else if (enable) begin
            r_result <= w_ext;
            r_valid  <= 1'b1;
        end else begin
            r_result <= '0;
            r_valid  <= 1'b0;
        end
    end

    assign result = r_result;
    assign valid  = r_valid;

endmodule

// File: tb/tb_sign_extend_unit.sv
// Scoreboard bench for sign_extend_unit: stimulus pushes expectations,
// a monitor pops and compares one cycle after each issued input.
module tb_sign_extend_unit;
    import seu_pkg::*;

    logic    clk;
    logic    rst;
    imm9_t   NR;
    logic    enable;
    logic    zext;
    word16_t result;
    logic    valid;

    sign_extend_unit dut (
        .clk    (clk),
        .rst    (rst),
        .NR     (NR),
        .enable (enable),
`ifdef SEU_ZEXT_EN
        .zext   (zext),
`endif
        .result (result),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic    v;
        word16_t r;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Reference: interpret NR as a signed (or unsigned) integer, then
    // take its 16-bit two's-complement encoding.
    function automatic word16_t ref_model(imm9_t nr, logic en, logic zx);
        int v;
        if (en !== 1'b1) return '0;
        v = int'(nr);
        if (zx !== 1'b1 && v >= 256) v = v - 512;
        return word16_t'(v);
    endfunction

    task automatic check(string nm, word16_t r, logic v,
                         word16_t er, logic ev);
        n_checks++;
        if (r === er && v === ev) begin
            n_pass++;
        end else begin
            $display("FAIL %s: result=%h valid=%b expected result=%h valid=%b",
                     nm, r, v, er, ev);
        end
    endtask

    task automatic apply(string nm, imm9_t nr, logic en, logic zx);
        exp_t e;
        @(negedge clk);
        NR     = nr;
        enable = en;
        zext   = zx;
        e.v    = (en === 1'b1);
        e.r    = ref_model(nr, en, zx);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        n_checks++;
        $display("FAIL drain: pending=%0d required=0", exp_q.size());
        exp_q.delete();
        name_q.delete();
    endtask

    // Monitor: one output per issued input, sampled 1 time unit after the edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, result, valid, e.r, e.v);
            end
        end
    end

    initial begin
        rst    = 1'b0;
        NR     = 9'h1AB;
        enable = 1'b1;
        zext   = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset_async_init", result, valid, 16'h0000, 1'b0);
        @(posedge clk);
        #1 check("reset_hold_edge", result, valid, 16'h0000, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;

        apply("first_after_release", 9'h005, 1'b1, 1'b0);
        apply("pos_max", 9'h0FF, 1'b1, 1'b0);
        apply("neg_min", 9'h100, 1'b1, 1'b0);
        apply("neg_one", 9'h1FF, 1'b1, 1'b0);
        apply("neg_180", 9'h180, 1'b1, 1'b0);
        apply("disable", 9'h1AB, 1'b0, 1'b0);
        apply("disable_x", 9'bx, 1'b0, 1'b0);
        apply("zero", 9'h000, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 1024; i++) begin
            apply("sweep", imm9_t'(i >> 1), i[0], 1'b0);
        end
        drain();

        // Asynchronous reset in mid-cycle over a loaded non-zero value.
        apply("preload", 9'h1FF, 1'b1, 1'b0);
        drain();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("reset_async_mid", result, valid, 16'h0000, 1'b0);
        NR     = 9'h0AA;
        enable = 1'b1;
        @(posedge clk);
        #1 check("reset_ignores_edge", result, valid, 16'h0000, 1'b0);
        #1 rst = 1'b0;
        apply("after_reset", 9'h0AA, 1'b1, 1'b0);

`ifdef SEU_ZEXT_EN
        apply("zext_on", 9'h1FF, 1'b1, 1'b1);
        apply("zext_off", 9'h1FF, 1'b1, 1'b0);
        apply("zext_disable", 9'h1FF, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 300; i++) begin
            logic zx;
`ifdef SEU_ZEXT_EN
            zx = 1'($urandom);
`else
            zx = 1'b0;
`endif
            apply("random", imm9_t'($urandom), 1'($urandom), zx);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
